// File: rtl/calc_entry.sv
// Operator front-end for the 4-bit signed calculator: debounced operand/opcode
// entry, latency-aware result capture, and full-precision overflow/div0 flags.

module calc_entry_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  logic [15:0] cnt_q, cnt_d;
  logic        lvl_q, lvl_d;
  logic        press_q, press_d;

  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (raw != lvl_q) begin
      if (cnt_q == CYCLES - 16'd1) begin
        lvl_d   = raw;
        press_d = raw;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module calc_entry #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CALC_LATENCY    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic [1:0] op_sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [3:0] calc_res,
  output logic [3:0] calc_a,
  output logic [3:0] calc_b,
  output logic [1:0] calc_op,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       ovf,
  output logic       div0,
  output logic [1:0] stage
);
  typedef enum logic [2:0] {S_GET_A, S_GET_B, S_GET_OP, S_WAIT, S_SHOW} state_t;

  localparam logic [7:0] LAT = CALC_LATENCY[7:0];

  state_t     state_q, state_d;
  logic [3:0] calc_a_q, calc_a_d, calc_b_q, calc_b_d, result_q, result_d;
  logic [1:0] calc_op_q, calc_op_d;
  logic       rv_q, rv_d, ovf_q, ovf_d, div0_q, div0_d;
  logic [7:0] wait_q, wait_d;
  logic       enter_p, clear_p;

  calc_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .rst(rst), .raw(btn_enter), .press(enter_p));
  calc_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .raw(btn_clear), .press(clear_p));

  // Flags come from the held operands, never from calc_res.
  logic signed [7:0] a_x, b_x, true_r;
  logic              ovf_c, div0_c;

  always_comb begin
    a_x    = {{4{calc_a_q[3]}}, calc_a_q};
    b_x    = {{4{calc_b_q[3]}}, calc_b_q};
    true_r = '0;
    ovf_c  = 1'b0;
    div0_c = 1'b0;
    case (calc_op_q)
      2'b00: true_r = a_x + b_x;
      2'b01: true_r = a_x - b_x;
      2'b10: true_r = a_x * b_x;
      default: true_r = '0;
    endcase
    if (calc_op_q == 2'b11) begin
      div0_c = (calc_b_q == 4'h0);
      ovf_c  = (calc_a_q == 4'h8) && (calc_b_q == 4'hF);
    end else begin
      ovf_c  = (true_r < -8'sd8) || (true_r > 8'sd7);
    end
  end

  always_comb begin
    state_d   = state_q;
    calc_a_d  = calc_a_q;
    calc_b_d  = calc_b_q;
    calc_op_d = calc_op_q;
    result_d  = result_q;
    rv_d      = rv_q;
    ovf_d     = ovf_q;
    div0_d    = div0_q;
    wait_d    = wait_q;
    if (clear_p) begin
      state_d   = S_GET_A;
      calc_a_d  = '0;
      calc_b_d  = '0;
      calc_op_d = '0;
      result_d  = '0;
      rv_d      = 1'b0;
      ovf_d     = 1'b0;
      div0_d    = 1'b0;
      wait_d    = '0;
    end else begin
      case (state_q)
        S_GET_A: if (enter_p) begin calc_a_d = sw; state_d = S_GET_B; end
        S_GET_B: if (enter_p) begin calc_b_d = sw; state_d = S_GET_OP; end
        S_GET_OP: if (enter_p) begin
          calc_op_d = op_sw;
          wait_d    = '0;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          // Capture on the (CALC_LATENCY+1)th edge after calc_op changed.
          if (wait_q == LAT) begin
            result_d = calc_res;
            ovf_d    = ovf_c;
            div0_d   = div0_c;
            rv_d     = 1'b1;
            state_d  = S_SHOW;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_SHOW: if (enter_p) begin
          rv_d    = 1'b0;
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          state_d = S_GET_A;
        end
        default: state_d = S_GET_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_GET_A;
      calc_a_q  <= '0;
      calc_b_q  <= '0;
      calc_op_q <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      ovf_q     <= 1'b0;
      div0_q    <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      calc_a_q  <= calc_a_d;
      calc_b_q  <= calc_b_d;
      calc_op_q <= calc_op_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      ovf_q     <= ovf_d;
      div0_q    <= div0_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    case (state_q)
      S_GET_A:          stage = 2'b00;
      S_GET_B:          stage = 2'b01;
      S_GET_OP, S_WAIT: stage = 2'b10;
      default:          stage = 2'b11;
    endcase
  end

  assign calc_a       = calc_a_q;
  assign calc_b       = calc_b_q;
  assign calc_op      = calc_op_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign ovf          = ovf_q;
  assign div0         = div0_q;
endmodule
